md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit driven by the decoder's `start`, `MDop`, `HIwrite` and `LOwrite` outputs.
- Holds the architectural HI/LO registers and runs multu/mult/divu/div/madd with a fixed multi-cycle latency.
- Asserts `busy` so the hazard unit can stall any MD-class instruction (MD_yes) in D while `start|busy`.
- Supplies HI/LO to the E-stage write-data mux used by mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for multu/mult/madd (legal range ≥1).
- DIV_CYCLES, 10, busy cycles for divu/div (legal range ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin an MD operation this cycle (E stage).
- MDop  in  3  000 multu, 001 mult, 010 divu, 011 div, 100 madd.
- HIwrite  in  1  mthi: HI <= A.
- LOwrite  in  1  mtlo: LO <= A.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- busy  out  1  operation in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset is asynchronous: HI=0, LO=0, busy=0, counter=0, FSM=IDLE, internal result registers cleared. Reset asserted mid-operation aborts the operation and no result is committed.
- FSM states are IDLE and RUN.
- IDLE with start=1 and MDop in {000..100}:
  - compute the 64-bit result from A, B (and current HI/LO for madd) into hidden result registers;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN; busy=1 from the next cycle.
- IDLE with start=1 and MDop in {101,110,111}: ignored, stay IDLE, no state change.
- RUN: counter decrements each cycle.
  - At the edge where counter goes 1→0: HI/LO <= result registers, busy <= 0, go to IDLE.
  - Sampling start at edge t gives busy high for exactly N cycles (t+1..t+N). New HI/LO are visible after edge t+N, the same edge busy falls.
- HI/LO are architecturally unchanged while busy. Reads during RUN return the old values; the controller must stall, and this block does not check for it.
- Arithmetic:
  - multu: {HI,LO} = zero-extended A × B.
  - mult: two's-complement signed 64-bit product.
  - madd: {HI,LO} = {HI,LO} + signed(A) × signed(B), mod 2^64. HI/LO are sampled at the start edge.
  - divu: LO = A / B, HI = A % B, both unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign. Overflow case 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - Divide by zero (div or divu): the operation still takes DIV_CYCLES with busy asserted; HI and LO are left unchanged at completion.
- mthi/mtlo:
  - Accepted only in IDLE. HI or LO is written with A at the next edge; both may be written in the same cycle.
  - Ignored while busy.
  - If start and HIwrite/LOwrite are both asserted in IDLE, start has priority and the writes are dropped.
- start asserted while busy is ignored; the in-flight operation is unaffected.
- Back-to-back: start may be accepted in the first IDLE cycle after completion. That cycle is edge t+N+1 for a start sampled at edge t.
- No combinational path from any input to busy, HI or LO; all outputs are registered.

Test Plan:
- Reset, then multu A=0xFFFFFFFF B=0xFFFFFFFF → busy high for 5 cycles; afterwards HI=0xFFFFFFFE, LO=0x00000001.
- mult A=0xFFFFFFFE (-2) B=0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA after 5 cycles. Read HI at cycle 3 → old value unchanged.
- Arithmetic and corner cases:
  - mthi 0x00000001, mtlo 0xFFFFFFFF, then madd A=1 B=1 → HI=0x00000002, LO=0x00000000.
  - madd A=0x80000000 B=0x80000000 from {HI,LO}=0 → HI=0x40000000, LO=0.
  - div A=0xFFFFFFF9 (-7) B=2 → busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7 B=0 → HI/LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Overlap and priority:
  - start divu during busy → ignored.
  - mtlo during busy → ignored.
  - start and LOwrite together in IDLE → only the MD result is committed.
  - start with MDop=111 → busy stays 0.
- Assert reset at RUN cycle 3 of a div → busy=0 and HI=LO=0 immediately (asynchronous). No commit afterwards; a new multu is accepted normally after reset deasserts.

Source files
------------

// File: rtl/md_unit_if.sv
// Handshake and data bus between the execute stage and the multiply/divide unit.
// The E stage drives the operands and controls; the unit returns busy and HI/LO.
interface md_unit_if;
    logic        start;
    logic [2:0]  MDop;
    logic        HIwrite;
    logic        LOwrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, MDop, HIwrite, LOwrite, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, MDop, HIwrite, LOwrite, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at the start edge and committed when the fixed latency expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_unit_if.slave    bus
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0]   hi_q, lo_q, hi_nx, lo_nx;
    logic [31:0]   res_hi, res_lo, res_hi_nx, res_lo_nx;
    logic          res_keep, res_keep_nx;

    // Signed and unsigned 64-bit products
    logic signed [63:0] sa, sb, prod_s;
    logic [63:0]        prod_u, madd_sum;

    assign sa       = {{32{bus.A[31]}}, bus.A};
    assign sb       = {{32{bus.B[31]}}, bus.B};
    assign prod_s   = sa * sb;
    assign prod_u   = {32'd0, bus.A} * {32'd0, bus.B};
    assign madd_sum = {hi_q, lo_q} + $unsigned(prod_s);

    // One unsigned divider serves both div and divu; signed div works on magnitudes.
    // The 0x80000000 / -1 overflow falls out naturally: |A| = 0x80000000, quotient sign positive.
    logic        is_sdiv, div_zero;
    logic [31:0] a_mag, b_mag, dvsr, q_u, r_u, quo, rem;

    assign is_sdiv  = (bus.MDop == 3'b011);
    assign div_zero = (bus.B == 32'd0);
    assign a_mag    = (is_sdiv && bus.A[31]) ? -bus.A : bus.A;
    assign b_mag    = (is_sdiv && bus.B[31]) ? -bus.B : bus.B;
    assign dvsr     = div_zero ? 32'd1 : b_mag;
    assign q_u      = a_mag / dvsr;
    assign r_u      = a_mag % dvsr;
    assign quo      = (is_sdiv && (bus.A[31] ^ bus.B[31])) ? -q_u : q_u;
    assign rem      = (is_sdiv && bus.A[31]) ? -r_u : r_u;

    logic op_valid, is_mul;
    assign op_valid = (bus.MDop <= 3'b100);
    assign is_mul   = bus.MDop[2] | ~bus.MDop[1];

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hi_nx       = hi_q;
        lo_nx       = lo_q;
        res_hi_nx   = res_hi;
        res_lo_nx   = res_lo;
        res_keep_nx = res_keep;
        case (state)
            IDLE: begin
                // start wins over mthi/mtlo, even when the opcode is unused
                if (bus.start) begin
                    if (op_valid) begin
                        state_nx    = RUN;
                        cnt_nx      = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        res_keep_nx = 1'b0;
                        case (bus.MDop)
                            3'b000:  {res_hi_nx, res_lo_nx} = prod_u;
                            3'b001:  {res_hi_nx, res_lo_nx} = $unsigned(prod_s);
                            3'b100:  {res_hi_nx, res_lo_nx} = madd_sum;
                            default: begin
                                {res_hi_nx, res_lo_nx} = {rem, quo};
                                res_keep_nx            = div_zero;
                            end
                        endcase
                    end
                end else begin
                    if (bus.HIwrite) hi_nx = bus.A;
                    if (bus.LOwrite) lo_nx = bus.A;
                end
            end
            RUN: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = IDLE;
                    if (!res_keep) begin
                        hi_nx = res_hi;
                        lo_nx = res_lo;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            res_keep <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            hi_q     <= hi_nx;
            lo_q     <= lo_nx;
            res_hi   <= res_hi_nx;
            res_lo   <= res_lo_nx;
            res_keep <= res_keep_nx;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: vector table, hand-written corner sequences and random traffic,
// all checked cycle by cycle against an arithmetic reference model.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_unit_if bus();
    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int passed = 0;

    // Reference model: absolute cycle numbers instead of a counter
    longint      cyc = 0;
    longint      m_done_at = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    logic        m_keep = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else passed++;
    endtask

    function automatic logic [64:0] ref_op(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                           logic [31:0] hi, logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return {1'b0, ua * ub};
            3'd1: return {1'b0, 64'(sa * sb)};
            3'd4: return {1'b0, {hi, lo} + 64'(sa * sb)};
            3'd2: begin
                if (b == 0) return {1'b1, 64'd0};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, 64'd0};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic m_step(bit s, logic [2:0] op, bit hw, bit lw, logic [31:0] a, logic [31:0] b);
        bit was_busy;
        was_busy = (cyc < m_done_at);
        cyc++;
        if (was_busy) begin
            if (cyc == m_done_at && !m_keep) {m_hi, m_lo} = m_res;
        end else if (s) begin
            if (op <= 3'd4) begin
                {m_keep, m_res} = ref_op(op, a, b, m_hi, m_lo);
                m_done_at = cyc + ((op == 3'd2 || op == 3'd3) ? DC : MC);
            end
        end else begin
            if (hw) m_hi = a;
            if (lw) m_lo = a;
        end
    endtask

    task automatic cycle(bit s, logic [2:0] op, bit hw, bit lw, logic [31:0] a, logic [31:0] b);
        bus.start = s; bus.MDop = op; bus.HIwrite = hw; bus.LOwrite = lw; bus.A = a; bus.B = b;
        @(posedge clk);
        m_step(s, op, hw, lw, a, b);
        #1;
        chk("busy", 32'(bus.busy), 32'(cyc < m_done_at));
        chk("HI", bus.HI, m_hi);
        chk("LO", bus.LO, m_lo);
    endtask

    task automatic idle();
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (bus.busy && g < 50) begin
            idle();
            g++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    bit          r_s, r_hw, r_lw;
    int          nbusy;

    initial begin
        vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[2] = '{3'd4, 32'h00000001, 32'h00000001, 32'h1, 32'hFFFFFFFF, 32'h00000002, 32'h0};
        vecs[3] = '{3'd4, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h0};
        vecs[4] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{3'd2, 32'h00000007, 32'h00000000, 32'h1234, 32'h5678, 32'h1234, 32'h5678};
        vecs[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h9, 32'h9, 32'h0, 32'h80000000};
        vecs[7] = '{3'd2, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14};

        bus.start = 0; bus.MDop = 0; bus.HIwrite = 0; bus.LOwrite = 0; bus.A = 0; bus.B = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_HI", bus.HI, 32'd0);
        chk("rst_LO", bus.LO, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            cycle(1'b0, 3'd0, 1'b1, 1'b0, vecs[i].pre_hi, 32'd0);
            cycle(1'b0, 3'd0, 1'b0, 1'b1, vecs[i].pre_lo, 32'd0);
            cycle(1'b1, vecs[i].op, 1'b0, 1'b0, vecs[i].a, vecs[i].b);
            nbusy = bus.busy ? 1 : 0;
            for (int g = 0; g < 40 && bus.busy; g++) begin
                idle();
                if (bus.busy) nbusy++;
            end
            chk($sformatf("v%0d_busy_len", i), 32'(nbusy),
                (vecs[i].op == 3'd2 || vecs[i].op == 3'd3) ? DC : MC);
            chk($sformatf("v%0d_HI", i), bus.HI, vecs[i].exp_hi);
            chk($sformatf("v%0d_LO", i), bus.LO, vecs[i].exp_lo);
        end

        // Reads during RUN see the old HI
        cycle(1'b0, 3'd0, 1'b1, 1'b0, 32'hAAAA5555, 32'd0);
        cycle(1'b1, 3'd1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd3);
        idle(); idle();
        chk("mult_hi_old", bus.HI, 32'hAAAA5555);
        wait_idle();
        chk("mult_hi_new", bus.HI, 32'hFFFFFFFF);

        // start and mtlo during busy are both ignored
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 32'd2, 32'd3);
        cycle(1'b1, 3'd2, 1'b0, 1'b0, 32'd100, 32'd3);
        cycle(1'b0, 3'd0, 1'b0, 1'b1, 32'hBEEF, 32'd0);
        wait_idle();
        chk("ovl_HI", bus.HI, 32'd0);
        chk("ovl_LO", bus.LO, 32'd6);

        // start beats LOwrite in IDLE
        cycle(1'b0, 3'd0, 1'b0, 1'b1, 32'hDEAD, 32'd0);
        cycle(1'b1, 3'd0, 1'b0, 1'b1, 32'd6, 32'd7);
        wait_idle();
        chk("prio_LO", bus.LO, 32'd42);

        // Unused opcode never raises busy
        cycle(1'b1, 3'd7, 1'b0, 1'b0, 32'd5, 32'd5);
        chk("op111_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a div
        cycle(1'b0, 3'd0, 1'b1, 1'b0, 32'h11112222, 32'd0);
        cycle(1'b0, 3'd0, 1'b0, 1'b1, 32'h33334444, 32'd0);
        cycle(1'b1, 3'd3, 1'b0, 1'b0, 32'd100, 32'd7);
        idle(); idle();
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_HI", bus.HI, 32'd0);
        chk("arst_LO", bus.LO, 32'd0);
        m_hi = '0; m_lo = '0; m_done_at = cyc;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) idle();
        chk("arst_nocommit", bus.LO, 32'd0);
        cycle(1'b1, 3'd0, 1'b0, 1'b0, 32'd3, 32'd5);
        wait_idle();
        chk("arst_multu", bus.LO, 32'd15);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r_s  = ($urandom % 3) == 0;
            r_op = 3'($urandom_range(0, 7));
            r_hw = ($urandom % 4) == 0;
            r_lw = ($urandom % 4) == 0;
            r_a  = ($urandom % 10 == 0) ? 32'h80000000 : $urandom;
            r_b  = ($urandom % 8 == 0) ? 32'd0 : (($urandom % 10 == 0) ? 32'hFFFFFFFF : $urandom);
            cycle(r_s, r_op, r_hw, r_lw, r_a, r_b);
        end
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
